ram_frame_loader: RTL

Write-side sequencer placed directly upstream of the 4x8 RAM. It accepts a stream of bytes over a valid/ready handshake and turns each group of four into sequential writes to RAM words 0..3. Each write is one registered write strobe with address and data. It also issues single-cycle clear commands to the RAM and reports per-frame status (done pulse, 8-bit checksum, frame count) to the controlling logic.

---
 rtl/ram_frame_loader.sv | 70 +++++++
 1 files changed

// File: rtl/ram_frame_loader.sv
// ram_frame_loader: turns a byte stream into sequential 4-word RAM frame writes,
// issues RAM clear strobes and reports per-frame done/checksum/count.
module ram_frame_loader #(
    parameter int WORDS  = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              CLK_,
    input  logic              CLR,
    input  logic              start,
    input  logic              clr_req,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_clr,
    output logic              busy,
    output logic              frame_done,
    output logic [DATA_W-1:0] checksum,
    output logic [7:0]        frame_count
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, CLEAR} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);
    state_t state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic accept, restart;
    always_comb begin
        in_ready   = (state == LOAD) && !clr_req;
        busy       = state != IDLE;
        frame_done = state == DONE;
        accept     = in_valid && in_ready;
        restart    = (state == IDLE && start && !clr_req) || state == CLEAR;
        state_nxt  = state;
        case (state)
            IDLE:    state_nxt = clr_req ? CLEAR : start ? LOAD : IDLE;
            LOAD:    state_nxt = clr_req ? CLEAR : (accept && idx == LAST) ? DONE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end
    // Write and clear strobes are registered so the RAM sees one clean cycle per command
    always_ff @(posedge CLK_ or negedge CLR) begin
        if (!CLR) begin
            state       <= IDLE;
            idx         <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_data    <= '0;
            ram_clr     <= 1'b0;
            checksum    <= '0;
            frame_count <= '0;
        end else begin
            state   <= state_nxt;
            ram_we  <= accept;
            ram_clr <= state_nxt == CLEAR;
            if (accept) begin
                ram_addr <= idx;
                ram_data <= in_data;
                checksum <= checksum + in_data;
                idx      <= idx + 1'b1;
            end
            if (restart) begin
                idx      <= '0;
                checksum <= '0;
            end
            if (state == LOAD && state_nxt == DONE) frame_count <= frame_count + 8'd1;
        end
    end
endmodule
